// File: rtl/div_result_fifo_if.sv
// Handshake bundle between divider controller, result FIFO and consumer.
// The divider side pushes results; the consumer side pops them.
interface div_result_fifo_if;
  logic       done;
  logic [9:0] q_in;
  logic       ovf_in;
  logic       dvz_in;
  logic       accept;
  logic       out_valid;
  logic       out_ready;
  logic [9:0] out_q;
  logic       out_ovf;
  logic       out_dvz;
  logic       full;
  logic [2:0] count;
  logic [7:0] drop_cnt;

  modport master (
    output done, q_in, ovf_in, dvz_in, out_ready,
    input  accept, out_valid, out_q, out_ovf, out_dvz,
    input  full, count, drop_cnt
  );

  modport slave (
    input  done, q_in, ovf_in, dvz_in, out_ready,
    output accept, out_valid, out_q, out_ovf, out_dvz,
    output full, count, drop_cnt
  );
endinterface

// File: rtl/div_result_fifo.sv
// 4-deep first-word-fall-through FIFO for divider results.
// Counts results lost to a full FIFO, saturating at 255.
module div_result_fifo (
  input logic            clk,
  input logic            rst,
  div_result_fifo_if.slave bus
);
  typedef logic [11:0] word_t;

  word_t      mem_q [4];
  word_t      mem_d [4];
  logic [1:0] wr_ptr_q, wr_ptr_d;
  logic [1:0] rd_ptr_q, rd_ptr_d;
  logic [2:0] count_q, count_d;
  logic [7:0] drop_q, drop_d;
  logic       empty, push, pop;
  word_t      wdata, head;

  always_comb begin
    empty    = (count_q == 3'd0);
    pop      = !empty && bus.out_ready;
    // a full FIFO still takes a push when the head leaves this cycle
    push     = bus.done && ((count_q != 3'd4) || pop);
    wdata    = bus.dvz_in ? 12'h800 : {1'b0, bus.ovf_in, bus.q_in};
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    drop_d   = drop_q;
    if (push) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + 2'd1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 2'd1;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 3'd1;
      2'b01:   count_d = count_q - 3'd1;
      default: count_d = count_q;
    endcase
    if (bus.done && !push && (drop_q != 8'hFF))
      drop_d = drop_q + 8'd1;
    head = empty ? 12'h000 : mem_q[rd_ptr_q];
  end

  assign bus.out_valid = !empty;
  assign bus.out_q     = head[9:0];
  assign bus.out_ovf   = head[10];
  assign bus.out_dvz   = head[11];
  assign bus.full      = (count_q == 3'd4);
  assign bus.accept    = (count_q != 3'd4);
  assign bus.count     = count_q;
  assign bus.drop_cnt  = drop_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= 2'd0;
      rd_ptr_q <= 2'd0;
      count_q  <= 3'd0;
      drop_q   <= 8'd0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      drop_q   <= drop_d;
    end
  end

  // storage is not cleared; stale words stay hidden behind count
  always_ff @(posedge clk) begin
    if (!rst) mem_q <= mem_d;
  end
endmodule

// File: tb/tb_div_result_fifo.sv
// Directed self-checking bench for div_result_fifo.
// Drives inputs and samples outputs 1ns after each rising edge.
module tb_div_result_fifo;
  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;

  div_result_fifo_if bus ();

  div_result_fifo dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.done      = 1'b0;
    bus.q_in      = 10'h000;
    bus.ovf_in    = 1'b0;
    bus.dvz_in    = 1'b0;
    bus.out_ready = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic push(input logic [9:0] q, input logic ovf, input logic dvz);
    bus.done   = 1'b1;
    bus.q_in   = q;
    bus.ovf_in = ovf;
    bus.dvz_in = dvz;
    step();
    idle();
  endtask

  task automatic pop_expect(input string tag, input int q);
    check(tag, bus.out_q, q);
    bus.out_ready = 1'b1;
    step();
    idle();
  endtask

  int exp_q[$];

  initial begin
    n_vec = 0;
    n_err = 0;
    rst   = 1'b0;
    idle();
    #2;
    do_reset();
    check("rst_count", bus.count, 0);
    check("rst_valid", bus.out_valid, 0);
    check("rst_full", bus.full, 0);
    check("rst_accept", bus.accept, 1);
    check("rst_drop", bus.drop_cnt, 0);
    check("rst_q", bus.out_q, 0);
    check("rst_ovf", bus.out_ovf, 0);
    check("rst_dvz", bus.out_dvz, 0);

    bus.out_ready = 1'b1;
    step();
    idle();
    check("empty_pop_count", bus.count, 0);

    push(10'h155, 1'b0, 1'b0);
    check("single_valid", bus.out_valid, 1);
    check("single_q", bus.out_q, 'h155);
    check("single_count", bus.count, 1);
    check("single_ovf", bus.out_ovf, 0);
    check("single_dvz", bus.out_dvz, 0);
    pop_expect("single_pop", 'h155);
    check("single_empty", bus.out_valid, 0);

    push(10'h2A3, 1'b1, 1'b0);
    check("ovf_q", bus.out_q, 'h2A3);
    check("ovf_flag", bus.out_ovf, 1);
    check("ovf_dvz", bus.out_dvz, 0);
    pop_expect("ovf_pop", 'h2A3);

    push(10'h3FF, 1'b1, 1'b1);
    check("dvz_q", bus.out_q, 0);
    check("dvz_ovf", bus.out_ovf, 0);
    check("dvz_flag", bus.out_dvz, 1);
    check("dvz_valid", bus.out_valid, 1);

    do_reset();
    for (int i = 1; i <= 5; i++) push(10'(i), 1'b0, 1'b0);
    check("fill_count", bus.count, 4);
    check("fill_full", bus.full, 1);
    check("fill_accept", bus.accept, 0);
    check("fill_drop", bus.drop_cnt, 1);
    for (int i = 1; i <= 4; i++) pop_expect("fill_pop", i);
    check("fill_empty", bus.out_valid, 0);
    check("fill_empty_q", bus.out_q, 0);
    check("fill_empty_cnt", bus.count, 0);

    do_reset();
    for (int i = 1; i <= 4; i++) push(10'(i), 1'b0, 1'b0);
    bus.out_ready = 1'b1;
    push(10'd9, 1'b0, 1'b0);
    check("fullpp_count", bus.count, 4);
    check("fullpp_drop", bus.drop_cnt, 0);
    pop_expect("fullpp_pop", 2);
    pop_expect("fullpp_pop", 3);
    pop_expect("fullpp_pop", 4);
    pop_expect("fullpp_pop", 9);
    check("fullpp_empty", bus.out_valid, 0);

    do_reset();
    exp_q.delete();
    for (int i = 0; i < 300; i++) begin
      if (exp_q.size() < 4) exp_q.push_back(i + 1);
      push(10'(i + 1), 1'b0, 1'b0);
    end
    check("sat_drop", bus.drop_cnt, 255);
    check("sat_count", bus.count, 4);
    for (int i = 0; i < 10; i++) begin
      check("wrap_head", bus.out_q, exp_q.pop_front());
      exp_q.push_back(100 + i);
      bus.out_ready = 1'b1;
      push(10'(100 + i), 1'b0, 1'b0);
      check("wrap_count", bus.count, 4);
    end
    check("wrap_drop", bus.drop_cnt, 255);
    for (int i = 0; i < 4; i++) pop_expect("wrap_drain", exp_q.pop_front());
    check("wrap_empty", bus.out_valid, 0);

    do_reset();
    for (int i = 1; i <= 3; i++) push(10'(i + 16), 1'b1, 1'b0);
    check("mid_count", bus.count, 3);
    rst           = 1'b1;
    bus.done      = 1'b1;
    bus.q_in      = 10'h0AA;
    bus.out_ready = 1'b1;
    step();
    rst = 1'b0;
    idle();
    check("mid_rst_count", bus.count, 0);
    check("mid_rst_valid", bus.out_valid, 0);
    check("mid_rst_drop", bus.drop_cnt, 0);
    check("mid_rst_q", bus.out_q, 0);
    check("mid_rst_ovf", bus.out_ovf, 0);
    check("mid_rst_dvz", bus.out_dvz, 0);
    check("mid_rst_accept", bus.accept, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/div_result_fifo.md
DIV_RESULT_FIFO -- requirements
Module: div_result_fifo

Interface
REQ-001 The block SHALL have exactly one clock and one reset; reset is synchronous and active-high.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 done  input  1  one-cycle pulse from the divider controller: q_in/ovf_in/dvz_in are valid this cycle.
REQ-005 q_in  input  10  unsigned fixed-point quotient from the divider datapath.
REQ-006 ovf_in  input  1  divider overflow flag.
REQ-007 dvz_in  input  1  divide-by-zero flag.
REQ-008 accept  output  1  to the divider controller: a result can be stored; equals !full.
REQ-009 out_valid  output  1  head entry available.
REQ-010 out_ready  input  1  consumer takes head when out_valid && out_ready.
REQ-011 out_q  output  10  head quotient.
REQ-012 out_ovf  output  1  head overflow flag.
REQ-013 out_dvz  output  1  head divide-by-zero flag.
REQ-014 full  output  1  4 entries stored.
REQ-015 count  output  3  entries stored, 0..4.
REQ-016 drop_cnt  output  8  results lost on push-while-full, saturating at 255.

Function
REQ-017 Storage SHALL be a 4-entry, 12-bit-wide ({dvz, ovf, q}) first-word-fall-through FIFO.
REQ-018 Push SHALL occur on a clk edge when done=1 and (count<4, or count=4 with a pop in the same cycle).
REQ-019 On push with dvz_in=1 the stored word SHALL be {1, 0, 10'h000} regardless of q_in/ovf_in.
REQ-020 On push with dvz_in=0 the stored word SHALL be {0, ovf_in, q_in} unmodified.
REQ-021 Pop SHALL occur on a clk edge when out_valid=1 and out_ready=1.
REQ-022 out_valid SHALL equal (count!=0); head fields SHALL reflect the oldest entry combinationally from storage, zero latency.
REQ-023 When count=0, out_q, out_ovf and out_dvz SHALL all be 0.
REQ-024 Push latency: a result pushed into an empty FIFO SHALL appear on out_* with out_valid=1 in the cycle after the done edge.
REQ-025 Simultaneous push and pop SHALL leave count unchanged; the new entry goes behind the remaining entries.
REQ-026 Simultaneous push and pop at count=4 SHALL accept the push (no drop).
REQ-027 done=1 at count=4 without a pop SHALL discard the result and increment drop_cnt unless already 255.
REQ-028 Pop at count=0 cannot occur (out_valid=0); out_ready is ignored when empty.
REQ-029 Read and write pointers SHALL be 2 bits and wrap 3->0; count SHALL be tracked separately, so full and empty are unambiguous.
REQ-030 full SHALL equal (count==4); accept SHALL equal !full, combinationally.

Reset
REQ-031 On rst=1 at a clk edge: count=0, pointers=0, drop_cnt=0, out_valid=0, full=0, accept=1, out_q=0, out_ovf=0, out_dvz=0.
REQ-032 rst SHALL take priority over done and out_ready in the same cycle; a push or pop requested in a reset cycle is lost and drop_cnt is not incremented.
REQ-033 Storage array contents need not be cleared; they SHALL be unobservable until rewritten.

Verification
REQ-034 Single result: reset, done with q_in=10'h155, ovf_in=0, dvz_in=0, out_ready=0 -> next cycle out_valid=1, out_q=10'h155, count=1.
REQ-035 DVZ masking: done with q_in=10'h3FF, ovf_in=1, dvz_in=1 -> head shows out_q=0, out_ovf=0, out_dvz=1.
REQ-036 Fill and drop: 5 consecutive done pulses (q=1..5), out_ready=0 -> count=4, full=1, accept=0, drop_cnt=1; pops yield 1,2,3,4 in order.
REQ-037 Full push+pop: at count=4 holding 1..4, done with q=9 and out_ready=1 in the same cycle -> count=4, drop_cnt=0, subsequent pops yield 2,3,4,9.
REQ-038 Wrap and saturation: 300 done pulses with out_ready=0 from empty -> drop_cnt=255; then 10 push/pop cycles with out_ready=1 -> FIFO order preserved across pointer wrap.
REQ-039 Reset mid-operation: count=3, assert rst together with done and out_ready -> next cycle count=0, out_valid=0, drop_cnt=0, all out_* = 0.
